// File: rtl/bumpy_status_tracker_if.sv
// Bundle between the level manager / video side and bumpy_status_tracker.
// master: drives frame strobe, collision levels, screen handshake and level index.
// slave : returns event pulses, lives/score/gift counters and grace flag.
interface bumpy_status_tracker_if;
  logic        startOfFrame;
  logic        hazard_hit;
  logic        gift_hit;
  logic        reset_fsm_N;
  logic [2:0]  lvl;
  logic        bumpy_died;
  logic        level_comp;
  logic        zero_lives;
  logic [2:0]  lives;
  logic [15:0] score;
  logic [3:0]  gifts_left;
  logic        invulnerable;

  modport master (
    output startOfFrame, hazard_hit, gift_hit, reset_fsm_N, lvl,
    input  bumpy_died, level_comp, zero_lives, lives, score, gifts_left, invulnerable
  );

  modport slave (
    input  startOfFrame, hazard_hit, gift_hit, reset_fsm_N, lvl,
    output bumpy_died, level_comp, zero_lives, lives, score, gifts_left, invulnerable
  );
endinterface

// File: rtl/bumpy_status_tracker.sv
// Game-event front end for the level manager.
// Turns raw hazard/gift collision levels into single-cycle bumpy_died /
// level_comp pulses, tracks lives, score and gifts remaining, and follows the
// level manager's died/win screen handshake (reset_fsm_N) before restarting
// play with a frame-counted grace period.
// Ports:
//   clk    - system clock
//   resetN - asynchronous active-low reset
//   bus    - slave side of bumpy_status_tracker_if (inputs: startOfFrame,
//            hazard_hit, gift_hit, reset_fsm_N, lvl; outputs: bumpy_died,
//            level_comp, zero_lives, lives, score, gifts_left, invulnerable)
module bumpy_status_tracker #(
  parameter int unsigned INIT_LIVES   = 3,
  parameter int unsigned GIFTS_BASE   = 4,
  parameter int unsigned GIFT_POINTS  = 10,
  parameter int unsigned LEVEL_BONUS  = 100,
  parameter int unsigned GRACE_FRAMES = 60,
  parameter int unsigned ACK_TIMEOUT  = 15
) (
  input logic                      clk,
  input logic                      resetN,
  bumpy_status_tracker_if.slave    bus
);

  typedef enum logic [2:0] {PLAY, DYING, WINNING, SCREEN, GRACE, GAME_OVER} state_t;

  state_t      state;
  logic        hz_prev, gf_prev;
  logic [2:0]  lives_q;
  logic [15:0] score_q;
  logic [3:0]  gifts_q;
  logic        gifts_loaded;
  logic        died_q, comp_q, zero_q, invul_q;
  logic [15:0] frame_cnt;
  logic [15:0] ack_cnt;

  logic        hz_ev, gf_ev;
  logic [3:0]  gifts_reload, gifts_cur, gifts_dec;
  logic        gift_last;
  logic [17:0] score_sum;
  logic [15:0] score_next;
  logic [2:0]  lives_dec;

  always_comb begin
    hz_ev        = bus.hazard_hit & ~hz_prev;
    gf_ev        = bus.gift_hit & ~gf_prev;
    gifts_reload = 4'(GIFTS_BASE + 32'(bus.lvl));
    // The reset value depends on lvl, which cannot be an async-load constant;
    // until the register is first written, the live reload value is shown.
    gifts_cur    = gifts_loaded ? gifts_q : gifts_reload;
    gift_last    = (gifts_cur == 4'd1);
    gifts_dec    = (gifts_cur != 4'd0) ? gifts_cur - 4'd1 : '0;
    score_sum    = {2'b00, score_q} + 18'(GIFT_POINTS) + (gift_last ? 18'(LEVEL_BONUS) : '0);
    score_next   = (score_sum > 18'h0FFFF) ? '1 : score_sum[15:0];
    lives_dec    = (lives_q != 3'd0) ? lives_q - 3'd1 : '0;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state        <= PLAY;
      hz_prev      <= 1'b0;
      gf_prev      <= 1'b0;
      lives_q      <= 3'(INIT_LIVES);
      score_q      <= '0;
      gifts_q      <= '0;
      gifts_loaded <= 1'b0;
      died_q       <= 1'b0;
      comp_q       <= 1'b0;
      zero_q       <= 1'b0;
      invul_q      <= 1'b0;
      frame_cnt    <= '0;
      ack_cnt      <= '0;
    end else begin
      hz_prev <= bus.hazard_hit;
      gf_prev <= bus.gift_hit;
      died_q  <= 1'b0;
      comp_q  <= 1'b0;
      if (!gifts_loaded) begin
        gifts_q      <= gifts_reload;
        gifts_loaded <= 1'b1;
      end

      case (state)
        PLAY, GRACE: begin
          if (state == PLAY && hz_ev) begin
            lives_q <= lives_dec;
            died_q  <= 1'b1;
            ack_cnt <= '0;
            if (lives_dec == 3'd0) begin
              zero_q <= 1'b1;
              state  <= GAME_OVER;
            end else begin
              state  <= DYING;
            end
          end else begin
            if (state == GRACE && bus.startOfFrame) begin
              if (frame_cnt == 16'(GRACE_FRAMES - 1)) begin
                state   <= PLAY;
                invul_q <= 1'b0;
              end else begin
                frame_cnt <= frame_cnt + 16'd1;
              end
            end
            // A level completion overrides a simultaneous grace expiry.
            if (gf_ev) begin
              gifts_q      <= gifts_dec;
              gifts_loaded <= 1'b1;
              score_q      <= score_next;
              if (gift_last) begin
                comp_q  <= 1'b1;
                invul_q <= 1'b0;
                ack_cnt <= '0;
                state   <= WINNING;
              end
            end
          end
        end

        DYING, WINNING: begin
          if (!bus.reset_fsm_N) begin
            state <= SCREEN;
          end else if (ack_cnt == 16'(ACK_TIMEOUT - 1)) begin
            gifts_q      <= gifts_reload;
            gifts_loaded <= 1'b1;
            frame_cnt    <= '0;
            invul_q      <= 1'b1;
            state        <= GRACE;
          end else begin
            ack_cnt <= ack_cnt + 16'd1;
          end
        end

        SCREEN: begin
          if (bus.reset_fsm_N) begin
            gifts_q      <= gifts_reload;
            gifts_loaded <= 1'b1;
            frame_cnt    <= '0;
            invul_q      <= 1'b1;
            state        <= GRACE;
          end
        end

        GAME_OVER: begin
          lives_q <= '0;
          zero_q  <= 1'b1;
        end

        default: state <= PLAY;
      endcase
    end
  end

  assign bus.bumpy_died   = died_q;
  assign bus.level_comp   = comp_q;
  assign bus.zero_lives   = zero_q;
  assign bus.lives        = lives_q;
  assign bus.score        = score_q;
  assign bus.gifts_left   = gifts_cur;
  assign bus.invulnerable = invul_q;

endmodule

// File: tb/tb_bumpy_status_tracker.sv
// Directed self-checking bench for bumpy_status_tracker.
// Main instance uses default parameters; a second instance with a large
// GIFT_POINTS drives the score up to the saturation boundary in few gifts.
module tb_bumpy_status_tracker;
  logic clk = 1'b0;
  logic resetN = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   died_n = 0;
  int   comp_n = 0;
  int   rule_viol = 0;
  logic prev_d = 1'b0, prev_c = 1'b0;

  always #5 clk = ~clk;

  bumpy_status_tracker_if m();
  bumpy_status_tracker_if s();

  bumpy_status_tracker dut (.clk(clk), .resetN(resetN), .bus(m));

  bumpy_status_tracker #(.GIFT_POINTS(32'h7FFC)) dut_sat (.clk(clk), .resetN(resetN), .bus(s));

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (m.bumpy_died) died_n++;
      if (m.level_comp) comp_n++;
      if ((m.bumpy_died && m.level_comp) || (m.bumpy_died && prev_d) || (m.level_comp && prev_c))
        rule_viol++;
      prev_d = m.bumpy_died;
      prev_c = m.level_comp;
    end
  endtask

  task automatic gift_pulse();
    m.gift_hit = 1'b1; tick(3);
    m.gift_hit = 1'b0; tick(2);
  endtask

  task automatic hazard_pulse();
    m.hazard_hit = 1'b1; tick(3);
    m.hazard_hit = 1'b0; tick(2);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      m.startOfFrame = 1'b1; tick(1);
      m.startOfFrame = 1'b0; tick(1);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    #12;
    checks++; if (m.lives !== 3'd3) begin errors++; $display("FAIL reset_lives: got %0d expected 3", m.lives); end
    checks++; if (m.score !== 16'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", m.score); end
    checks++; if (m.gifts_left !== 4'd4) begin errors++; $display("FAIL reset_gifts: got %0d expected 4", m.gifts_left); end
    checks++; if ({m.bumpy_died, m.level_comp, m.zero_lives, m.invulnerable} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {m.bumpy_died, m.level_comp, m.zero_lives, m.invulnerable}); end
    @(negedge clk);
    resetN = 1'b1;
    tick(2);
  endtask

  task automatic test_gifts();
    logic [3:0] exp_g [4];
    exp_g[0] = 4'd3; exp_g[1] = 4'd2; exp_g[2] = 4'd1; exp_g[3] = 4'd0;
    comp_n = 0;
    for (int i = 0; i < 4; i++) begin
      m.gift_hit = 1'b1; tick(3);
      checks++; if (m.gifts_left !== exp_g[i]) begin errors++; $display("FAIL gift_count_%0d: got %0d expected %0d", i, m.gifts_left, exp_g[i]); end
      m.gift_hit = 1'b0; tick(2);
    end
    checks++; if (m.score !== 16'd140) begin errors++; $display("FAIL gift_score: got %0d expected 140", m.score); end
    checks++; if (comp_n !== 1) begin errors++; $display("FAIL level_comp_cycles: got %0d expected 1", comp_n); end
    gift_pulse();
    checks++; if (m.gifts_left !== 4'd0 || m.score !== 16'd140) begin
      errors++; $display("FAIL winning_ignores_gift: got gifts=%0d score=%0d expected 0/140", m.gifts_left, m.score); end
    m.lvl = 3'd1;
    m.reset_fsm_N = 1'b0; tick(10);
    m.reset_fsm_N = 1'b1; tick(2);
    checks++; if (m.gifts_left !== 4'd5 || m.invulnerable !== 1'b1) begin
      errors++; $display("FAIL win_reload: got gifts=%0d inv=%b expected 5/1", m.gifts_left, m.invulnerable); end
  endtask

  task automatic test_grace();
    died_n = 0;
    hazard_pulse();
    checks++; if (died_n !== 0 || m.lives !== 3'd3) begin
      errors++; $display("FAIL grace_hazard: got died=%0d lives=%0d expected 0/3", died_n, m.lives); end
    frames(59);
    checks++; if (m.invulnerable !== 1'b1) begin errors++; $display("FAIL grace_59: got inv=%b expected 1", m.invulnerable); end
    frames(1);
    checks++; if (m.invulnerable !== 1'b0) begin errors++; $display("FAIL grace_60: got inv=%b expected 0", m.invulnerable); end
  endtask

  task automatic test_hazard_held();
    gift_pulse();
    checks++; if (m.gifts_left !== 4'd4 || m.score !== 16'd150) begin
      errors++; $display("FAIL play_gift: got gifts=%0d score=%0d expected 4/150", m.gifts_left, m.score); end
    died_n = 0;
    m.hazard_hit = 1'b1; tick(1);
    m.reset_fsm_N = 1'b0; tick(100);
    m.reset_fsm_N = 1'b1; tick(399);
    m.hazard_hit = 1'b0; tick(2);
    checks++; if (died_n !== 1) begin errors++; $display("FAIL held_hazard_pulses: got %0d expected 1", died_n); end
    checks++; if (m.lives !== 3'd2) begin errors++; $display("FAIL held_hazard_lives: got %0d expected 2", m.lives); end
    checks++; if (m.gifts_left !== 4'd5 || m.invulnerable !== 1'b1) begin
      errors++; $display("FAIL died_reload: got gifts=%0d inv=%b expected 5/1", m.gifts_left, m.invulnerable); end
    frames(60);
    checks++; if (m.invulnerable !== 1'b0) begin errors++; $display("FAIL resume_play: got inv=%b expected 0", m.invulnerable); end
  endtask

  task automatic test_same_cycle();
    died_n = 0; comp_n = 0;
    m.hazard_hit = 1'b1; m.gift_hit = 1'b1; tick(3);
    m.hazard_hit = 1'b0; m.gift_hit = 1'b0; tick(2);
    checks++; if (died_n !== 1 || m.lives !== 3'd1) begin
      errors++; $display("FAIL same_cycle_died: got died=%0d lives=%0d expected 1/1", died_n, m.lives); end
    checks++; if (m.gifts_left !== 4'd5 || m.score !== 16'd150 || comp_n !== 0) begin
      errors++; $display("FAIL same_cycle_gift: got gifts=%0d score=%0d comp=%0d expected 5/150/0", m.gifts_left, m.score, comp_n); end
  endtask

  task automatic test_timeout();
    m.lvl = 3'd2;
    checks++; if (m.invulnerable !== 1'b0) begin errors++; $display("FAIL timeout_early: got inv=%b expected 0", m.invulnerable); end
    tick(15);
    checks++; if (m.invulnerable !== 1'b1 || m.gifts_left !== 4'd6) begin
      errors++; $display("FAIL timeout_grace: got inv=%b gifts=%0d expected 1/6", m.invulnerable, m.gifts_left); end
    gift_pulse();
    checks++; if (m.gifts_left !== 4'd5 || m.score !== 16'd160) begin
      errors++; $display("FAIL grace_gift: got gifts=%0d score=%0d expected 5/160", m.gifts_left, m.score); end
    frames(60);
    checks++; if (m.invulnerable !== 1'b0) begin errors++; $display("FAIL timeout_resume: got inv=%b expected 0", m.invulnerable); end
  endtask

  task automatic test_game_over();
    died_n = 0; comp_n = 0;
    hazard_pulse();
    checks++; if (died_n !== 1 || m.lives !== 3'd0 || m.zero_lives !== 1'b1) begin
      errors++; $display("FAIL last_death: got died=%0d lives=%0d zero=%b expected 1/0/1", died_n, m.lives, m.zero_lives); end
    hazard_pulse();
    gift_pulse();
    m.reset_fsm_N = 1'b0; tick(3);
    m.reset_fsm_N = 1'b1; tick(3);
    frames(5);
    gift_pulse();
    checks++; if (died_n !== 1 || comp_n !== 0 || m.lives !== 3'd0 || m.zero_lives !== 1'b1) begin
      errors++; $display("FAIL game_over_hold: got died=%0d comp=%0d lives=%0d zero=%b expected 1/0/0/1", died_n, comp_n, m.lives, m.zero_lives); end
    checks++; if (m.score !== 16'd160 || m.gifts_left !== 4'd5 || m.invulnerable !== 1'b0) begin
      errors++; $display("FAIL game_over_frozen: got score=%0d gifts=%0d inv=%b expected 160/5/0", m.score, m.gifts_left, m.invulnerable); end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 2; i++) begin
      s.gift_hit = 1'b1; tick(2);
      s.gift_hit = 1'b0; tick(2);
    end
    checks++; if (s.score !== 16'hFFF8) begin errors++; $display("FAIL sat_preload: got %h expected fff8", s.score); end
    s.gift_hit = 1'b1; tick(2);
    s.gift_hit = 1'b0; tick(2);
    checks++; if (s.score !== 16'hFFFF || s.gifts_left !== 4'd1) begin
      errors++; $display("FAIL sat_score: got score=%h gifts=%0d expected ffff/1", s.score, s.gifts_left); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); resetN = 1'b0;
    m.lvl = 3'd0;
    @(negedge clk); resetN = 1'b1;
    tick(2);
    gift_pulse();
    m.hazard_hit = 1'b1; tick(2);
    m.hazard_hit = 1'b0;
    m.reset_fsm_N = 1'b0; tick(3);
    checks++; if (m.score !== 16'd10 || m.lives !== 3'd2 || m.gifts_left !== 4'd3) begin
      errors++; $display("FAIL pre_reset: got score=%0d lives=%0d gifts=%0d expected 10/2/3", m.score, m.lives, m.gifts_left); end
    @(posedge clk); #3;
    resetN = 1'b0;
    #1;
    checks++; if (m.lives !== 3'd3 || m.score !== 16'd0 || m.gifts_left !== 4'd4) begin
      errors++; $display("FAIL async_reset_counts: got lives=%0d score=%0d gifts=%0d expected 3/0/4", m.lives, m.score, m.gifts_left); end
    checks++; if ({m.bumpy_died, m.level_comp, m.zero_lives, m.invulnerable} !== 4'b0000) begin
      errors++; $display("FAIL async_reset_flags: got %b expected 0000", {m.bumpy_died, m.level_comp, m.zero_lives, m.invulnerable}); end
    checks++; if (s.score !== 16'd0) begin errors++; $display("FAIL async_reset_sat: got %h expected 0", s.score); end
    m.reset_fsm_N = 1'b1;
    @(negedge clk); resetN = 1'b1;
    tick(2);
  endtask

  initial begin
    m.startOfFrame = 1'b0; m.hazard_hit = 1'b0; m.gift_hit = 1'b0; m.reset_fsm_N = 1'b1; m.lvl = 3'd0;
    s.startOfFrame = 1'b0; s.hazard_hit = 1'b0; s.gift_hit = 1'b0; s.reset_fsm_N = 1'b1; s.lvl = 3'd0;
    test_reset();
    test_gifts();
    test_grace();
    test_hazard_held();
    test_same_cycle();
    test_timeout();
    test_game_over();
    checks++; if (rule_viol !== 0) begin errors++; $display("FAIL pulse_rules: got %0d violations expected 0", rule_viol); end
    test_saturate();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
